spi_slave_regs: RTL and testbench

- Fabric SPI slave (mode 0, MSB first) that gives the host MCU register access to the FPGA application.
- It sits upstream of the GPIO/LED output logic: host frames are decoded into a small register file whose contents drive gpio_out and the control byte.
- All SPI pins are oversampled in the clk_pll_o domain; no logic is clocked by SCK.

---
 rtl/spi_regs_pkg.sv | 20 ++
 rtl/spi_pin_sync.sv | 36 +++
 rtl/spi_slave_regs.sv | 207 ++++++++++++++++++++
 tb/tb_spi_slave_regs.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_regs_pkg.sv
// rtl/spi_regs_pkg.sv - shared types and register map for the SPI register slave
package spi_regs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [6:0] ADDR_ID       = 7'h00;
  localparam logic [6:0] ADDR_CTRL     = 7'h01;
  localparam logic [6:0] ADDR_GPIO_LO  = 7'h02;
  localparam logic [6:0] ADDR_GPIO_MID = 7'h03;
  localparam logic [6:0] ADDR_GPIO_HI  = 7'h04;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = $clog2(FRAME_BITS);

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - multi-flop synchroniser with rise/fall detection on the synchronised level
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic clk_pll_o,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_pll_o or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      prev_q <= IDLE_LEVEL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave_regs.sv
// rtl/spi_slave_regs.sv - mode-0 SPI slave decoding 16-bit frames into a small register file
module spi_slave_regs
  import spi_regs_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input  logic        clk_pll_o,
  input  logic        rst_n,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [7:0]  ctrl,
  output logic [17:0] gpio_out,
  output logic        wr_pulse,
  output logic [6:0]  wr_addr,
  output logic        frame_err
);

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic unused_mosi_edges;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sck (
    .clk_pll_o(clk_pll_o), .rst_n(rst_n), .pin_i(spi_sck),
    .level_o(sck_level), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
    .clk_pll_o(clk_pll_o), .rst_n(rst_n), .pin_i(spi_cs_n),
    .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_mosi (
    .clk_pll_o(clk_pll_o), .rst_n(rst_n), .pin_i(spi_mosi),
    .level_o(mosi_level), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused_mosi_edges = mosi_rise ^ mosi_fall ^ sck_level;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [6:0]         rx_q, rx_d;
  logic [7:0]         tx_q, tx_d;
  logic               rw_q, rw_d;
  logic [6:0]         addr_q, addr_d;
  logic               miso_q, miso_d;
  logic [7:0]         ctrl_q, ctrl_d;
  logic [7:0]         gpio_lo_q, gpio_lo_d;
  logic [7:0]         gpio_mid_q, gpio_mid_d;
  logic [1:0]         gpio_hi_q, gpio_hi_d;
  logic               wr_pulse_q, wr_pulse_d;
  logic [6:0]         wr_addr_q, wr_addr_d;
  logic               frame_err_q, frame_err_d;
  logic [SYNC_STAGES:0] prime_q, prime_d;
  logic               armed_q, armed_d;

  logic [7:0] rx_byte;
  logic [7:0] rd_value;
  logic       byte_done, data_done;

  assign rx_byte   = {rx_q, mosi_level};
  assign byte_done = sck_rise && (bit_cnt_q[2:0] == 3'd7);
  assign data_done = (state_q == DATA) && byte_done;

  always_comb begin
    rd_value = 8'h00;
    case (rx_byte[6:0])
      ADDR_ID:       rd_value = ID_VALUE;
      ADDR_CTRL:     rd_value = ctrl_q;
      ADDR_GPIO_LO:  rd_value = gpio_lo_q;
      ADDR_GPIO_MID: rd_value = gpio_mid_q;
      ADDR_GPIO_HI:  rd_value = {6'b0, gpio_hi_q};
      default:       rd_value = 8'h00;
    endcase
  end

  always_ff @(posedge clk_pll_o or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall && armed_q) state_d = CMD;
      CMD:     if (byte_done) state_d = DATA;
      DATA:    if (byte_done) state_d = DONE;
      default: state_d = state_q;
    endcase
    if (cs_rise) state_d = IDLE;
  end

  // Frames are accepted only after CS has been seen high with settled synchronisers,
  // so a CS held low across reset cannot start a frame from the reset-injected edge.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    ctrl_d      = ctrl_q;
    gpio_lo_d   = gpio_lo_q;
    gpio_mid_d  = gpio_mid_q;
    gpio_hi_d   = gpio_hi_q;
    wr_addr_d   = wr_addr_q;
    wr_pulse_d  = 1'b0;
    frame_err_d = 1'b0;
    prime_d     = {prime_q[SYNC_STAGES-1:0], 1'b1};
    armed_d     = armed_q | (prime_q[SYNC_STAGES] & cs_level);

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall && armed_q) bit_cnt_d = '0;
      end
      CMD: begin
        if (sck_rise) begin
          rx_d      = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (byte_done) begin
            rw_d   = rx_byte[7];
            addr_d = rx_byte[6:0];
            tx_d   = rx_byte[7] ? 8'h00 : rd_value;
          end
        end
      end
      DATA: begin
        if (sck_rise) begin
          rx_d      = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (byte_done && rw_q) begin
            case (addr_q)
              ADDR_CTRL:     ctrl_d     = rx_byte;
              ADDR_GPIO_LO:  gpio_lo_d  = rx_byte;
              ADDR_GPIO_MID: gpio_mid_d = rx_byte;
              ADDR_GPIO_HI:  gpio_hi_d  = rx_byte[1:0];
              default:       ;
            endcase
            wr_addr_d  = addr_q;
            wr_pulse_d = 1'b1;
          end
        end
        if (sck_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
      default: miso_d = 1'b0;
    endcase

    // A coincident final SCK edge completes the frame before CS is considered.
    if (cs_rise) begin
      miso_d = 1'b0;
      if ((state_q == CMD || state_q == DATA) && !data_done &&
          (bit_cnt_q != '0 || sck_rise))
        frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_pll_o or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      ctrl_q      <= '0;
      gpio_lo_q   <= '0;
      gpio_mid_q  <= '0;
      gpio_hi_q   <= '0;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
      prime_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      ctrl_q      <= ctrl_d;
      gpio_lo_q   <= gpio_lo_d;
      gpio_mid_q  <= gpio_mid_d;
      gpio_hi_q   <= gpio_hi_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
      prime_q     <= prime_d;
      armed_q     <= armed_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = ~cs_level;
  assign ctrl        = ctrl_q;
  assign gpio_out    = {gpio_hi_q, gpio_mid_q, gpio_lo_q};
  assign wr_pulse    = wr_pulse_q;
  assign wr_addr     = wr_addr_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb/tb_spi_slave_regs.sv - scoreboard bench for spi_slave_regs against a register-map model
module tb_spi_slave_regs;

  logic        clk_pll_o = 1'b0;
  logic        rst_n     = 1'b0;
  logic        spi_sck   = 1'b0;
  logic        spi_cs_n  = 1'b1;
  logic        spi_mosi  = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [7:0]  ctrl;
  logic [17:0] gpio_out;
  logic        wr_pulse;
  logic [6:0]  wr_addr;
  logic        frame_err;

  spi_slave_regs #(.SYNC_STAGES(2), .ID_VALUE(8'hA5)) dut (
    .clk_pll_o(clk_pll_o), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .ctrl(ctrl),
    .gpio_out(gpio_out), .wr_pulse(wr_pulse), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  always #5 clk_pll_o = ~clk_pll_o;

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  ctrl;
    logic [17:0] gpio;
  } wr_exp_t;

  int         tests = 0;
  int         fails = 0;
  wr_exp_t    exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] obs_rd_q[$];
  logic [7:0] regs [0:4];
  int         fe_exp = 0;
  int         fe_seen = 0;
  logic       fe_prev = 1'b0;
  wr_exp_t    e;
  logic [23:0] rx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] a);
    if (a == 7'h00) return 8'hA5;
    if (a <= 7'h04) return regs[a[2:0]];
    return 8'h00;
  endfunction

  function automatic logic [17:0] model_gpio();
    return {regs[4][1:0], regs[3], regs[2]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) regs[i] = 8'h00;
  endtask

  task automatic model_write(input logic [6:0] a, input logic [7:0] d);
    if (a >= 7'h01 && a <= 7'h03) regs[a[2:0]] = d;
    else if (a == 7'h04) regs[4] = d & 8'h03;
    exp_wr_q.push_back('{addr: a, ctrl: regs[1], gpio: model_gpio()});
  endtask

  always @(negedge clk_pll_o) begin
    if (wr_pulse) begin
      if (exp_wr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wr_pulse: got wr_pulse=1 wr_addr=%0h expected no write", wr_addr);
      end else begin
        e = exp_wr_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("ctrl_after_write", 32'(ctrl), 32'(e.ctrl));
        check("gpio_after_write", 32'(gpio_out), 32'(e.gpio));
      end
    end
    if (frame_err) begin
      fe_seen++;
      if (fe_prev) begin
        tests++;
        fails++;
        $display("FAIL frame_err_width: got frame_err high 2 cycles expected 1");
      end
    end
    fe_prev <= frame_err;
    while (obs_rd_q.size() > 0 && exp_rd_q.size() > 0)
      check("miso_byte", 32'(obs_rd_q.pop_front()), 32'(exp_rd_q.pop_front()));
  end

  task automatic spi_bits(input logic [23:0] word, input int n, output logic [23:0] rx_o);
    rx_o = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = word[23-i];
      #50 spi_sck = 1'b1;
      rx_o = {rx_o[22:0], spi_miso};
      #50 spi_sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [23:0] word, input int n, output logic [23:0] rx_o);
    @(negedge clk_pll_o);
    spi_cs_n = 1'b0;
    #100;
    spi_bits(word, n, rx_o);
    #100 spi_cs_n = 1'b1;
    #200;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    logic [23:0] r;
    model_write(a, d);
    exp_rd_q.push_back(8'h00);
    spi_frame({1'b1, a, d, 8'h00}, 16, r);
    obs_rd_q.push_back(r[7:0]);
  endtask

  task automatic do_read(input logic [6:0] a);
    logic [23:0] r;
    exp_rd_q.push_back(model_read(a));
    spi_frame({1'b0, a, 8'h00, 8'h00}, 16, r);
    obs_rd_q.push_back(r[7:0]);
  endtask

  initial begin
    model_reset();
    #22;
    check("reset_miso", 32'(spi_miso), 0);
    check("reset_miso_oe", 32'(spi_miso_oe), 0);
    check("reset_ctrl", 32'(ctrl), 0);
    check("reset_gpio", 32'(gpio_out), 0);
    check("reset_wr_pulse", 32'(wr_pulse), 0);
    check("reset_wr_addr", 32'(wr_addr), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    #28 rst_n = 1'b1;
    #200;

    do_read(7'h00);
    do_write(7'h02, 8'h3C);
    do_write(7'h04, 8'hFF);
    do_read(7'h04);

    fe_exp++;
    spi_frame({8'h81, 8'hA0, 8'h00}, 12, rx);
    check("ctrl_after_abort", 32'(ctrl), 32'(regs[1]));
    do_read(7'h01);

    model_write(7'h01, 8'h5A);
    exp_rd_q.push_back(8'h00);
    exp_rd_q.push_back(8'h00);
    spi_frame({8'h81, 8'h5A, 8'hC3}, 24, rx);
    obs_rd_q.push_back(rx[15:8]);
    obs_rd_q.push_back(rx[7:0]);
    check("ctrl_overclock", 32'(ctrl), 32'h5A);

    @(negedge clk_pll_o);
    spi_cs_n = 1'b0;
    #100;
    spi_bits({8'h83, 8'h77, 8'h00}, 10, rx);
    rst_n = 1'b0;
    model_reset();
    #30;
    check("midreset_gpio", 32'(gpio_out), 0);
    check("midreset_ctrl", 32'(ctrl), 0);
    check("midreset_wr_addr", 32'(wr_addr), 0);
    check("midreset_miso_oe", 32'(spi_miso_oe), 0);
    #20 rst_n = 1'b1;
    #100;
    spi_bits({8'h77 << 2, 16'h0000}, 6, rx);
    #100 spi_cs_n = 1'b1;
    #200;
    check("stale_gpio", 32'(gpio_out), 0);
    do_read(7'h03);

    do_write(7'h10, 8'h11);
    do_read(7'h10);
    do_write(7'h00, 8'h12);
    do_read(7'h00);

    for (int i = 0; i < 40; i++) begin
      int unsigned pick;
      logic [6:0] a;
      logic [7:0] d;
      pick = $urandom_range(0, 6);
      a = (pick <= 4) ? 7'(pick) : 7'($urandom_range(5, 127));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, d);
      else do_read(a);
    end
    do_read(7'h04);

    #500;
    check("pending_writes", 32'(exp_wr_q.size()), 0);
    check("pending_reads", 32'(exp_rd_q.size()), 0);
    check("frame_err_count", 32'(fe_seen), 32'(fe_exp));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
